// File: rtl/multicycle_ctrl_if.sv
// Handshake and control bundle between the multi-cycle sequencer and the datapath/memories.
interface multicycle_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       opcode;
    logic [1:0]       tipo;
    logic             reg_write;
    logic             mem_to_reg;
    logic             mem_write;
    logic             branch;
    logic             zero;
    logic             imem_ready;
    logic             dmem_ready;
    logic             imem_req;
    logic             ir_we;
    logic             alu_en;
    logic             dmem_req;
    logic             dmem_we;
    logic             rf_we;
    logic             pc_we;
    logic             pc_src;
    logic [2:0]       state;
    logic [CNT_W-1:0] instr_count;
    logic             halted;
    logic             fault;

    modport master (
        input  opcode, tipo, reg_write, mem_to_reg, mem_write, branch, zero,
               imem_ready, dmem_ready,
        output imem_req, ir_we, alu_en, dmem_req, dmem_we, rf_we, pc_we, pc_src,
               state, instr_count, halted, fault
    );

    modport slave (
        output opcode, tipo, reg_write, mem_to_reg, mem_write, branch, zero,
               imem_ready, dmem_ready,
        input  imem_req, ir_we, alu_en, dmem_req, dmem_we, rf_we, pc_we, pc_src,
               state, instr_count, halted, fault
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB with halt, memory watchdog and retire counter.
// state  | meaning
// FETCH  | request instruction, load IR on imem_ready
// DECODE | latch decoder fields, detect halt opcode
// EXEC   | ALU cycle; branches retire here
// MEM    | data access; stores retire here
// WB     | register write-back and retire
// HALT   | parked until reset
// FAULT  | memory watchdog expired, parked until reset
module multicycle_ctrl #(
    parameter int         MEM_TIMEOUT = 15,
    parameter logic [3:0] HALT_OP     = 4'b1111,
    parameter int         CNT_W       = 16
) (
    input logic               clk,
    input logic               rst,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    localparam int TMR_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(MEM_TIMEOUT);

    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] count_q;
    logic [1:0]       tipo_l;
    logic             reg_write_l, mem_to_reg_l, mem_write_l, branch_l;
    logic             latch_dec;
    logic             imem_req, ir_we, alu_en, dmem_req, dmem_we, rf_we, pc_we, pc_src;
    logic             halted, fault;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FETCH;
            timer_q      <= '0;
            count_q      <= '0;
            tipo_l       <= '0;
            reg_write_l  <= 1'b0;
            mem_to_reg_l <= 1'b0;
            mem_write_l  <= 1'b0;
            branch_l     <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            if (pc_we) begin
                count_q <= count_q + CNT_W'(1);
            end
            if (latch_dec) begin
                tipo_l       <= bus.tipo;
                reg_write_l  <= bus.reg_write;
                mem_to_reg_l <= bus.mem_to_reg;
                mem_write_l  <= bus.mem_write;
                branch_l     <= bus.branch;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        latch_dec = 1'b0;
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        alu_en    = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        rf_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = 1'b0;
        halted    = 1'b0;
        fault     = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (bus.imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (timer_q == TMR_LIMIT) begin
                    state_d = S_FAULT;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_DECODE: begin
                latch_dec = 1'b1;
                state_d   = (bus.opcode == HALT_OP) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                alu_en = 1'b1;
                case (tipo_l)
                    2'b00, 2'b01: state_d = S_WB;
                    2'b10:        state_d = S_MEM;
                    default: begin
                        pc_we   = 1'b1;
                        pc_src  = branch_l & bus.zero;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = mem_write_l;
                if (bus.dmem_ready) begin
                    if (mem_to_reg_l) begin
                        state_d = S_WB;
                    end else begin
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (timer_q == TMR_LIMIT) begin
                    state_d = S_FAULT;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_WB: begin
                rf_we   = reg_write_l;
                pc_we   = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT:  halted = 1'b1;
            S_FAULT: fault  = 1'b1;
            default: state_d = S_FAULT;
        endcase
        // Every state change restarts the watchdog, so it counts only the current wait.
        if (state_d != state_q) begin
            timer_d = '0;
        end
    end

    assign bus.imem_req    = imem_req & ~rst;
    assign bus.ir_we       = ir_we    & ~rst;
    assign bus.alu_en      = alu_en   & ~rst;
    assign bus.dmem_req    = dmem_req & ~rst;
    assign bus.dmem_we     = dmem_we  & ~rst;
    assign bus.rf_we       = rf_we    & ~rst;
    assign bus.pc_we       = pc_we    & ~rst;
    assign bus.pc_src      = pc_src   & ~rst;
    assign bus.halted      = halted   & ~rst;
    assign bus.fault       = fault    & ~rst;
    assign bus.state       = state_q;
    assign bus.instr_count = count_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: per-instruction timeline and strobe tallies from a latency model.
module tb_multicycle_ctrl;
    localparam int MEM_TIMEOUT = 15;
    localparam int CNT_W       = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_cnt  = 0;

    multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

    multicycle_ctrl #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .HALT_OP    (4'b1111),
        .CNT_W      (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    logic [9:0] strobes;
    assign strobes = {bus.imem_req, bus.ir_we, bus.alu_en, bus.dmem_req, bus.dmem_we,
                      bus.rf_we, bus.pc_we, bus.pc_src, bus.halted, bus.fault};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_count();
        return 32'(exp_cnt % (1 << CNT_W));
    endfunction

    task automatic drive_dec(input logic [3:0] op, input logic [1:0] t,
                             input logic rw, input logic m2r, input logic mw, input logic br);
        bus.opcode     = op;
        bus.tipo       = t;
        bus.reg_write  = rw;
        bus.mem_to_reg = m2r;
        bus.mem_write  = mw;
        bus.branch     = br;
    endtask

    task automatic scramble_dec();
        drive_dec(4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            scramble_dec();
            bus.zero       = 1'($urandom);
            bus.imem_ready = 1'($urandom);
            bus.dmem_ready = 1'($urandom);
            @(negedge clk);
            check_eq("rst_strobes", 32'(strobes), 32'd0);
            @(posedge clk);
            #1;
        end
        rst     = 1'b0;
        exp_cnt = 0;
        check_eq("rst_state", 32'(bus.state), 32'd0);
        check_eq("rst_count", 32'(bus.instr_count), 32'd0);
    endtask

    // One instruction from FETCH to its retire cycle; expectations come from the latency rules.
    task automatic run_instr(input logic [1:0] t, input logic rw, input logic m2r, input logic mw,
                             input logic br, input logic z, input int imw, input int dmw);
        int         q[$];
        int         cyc, fetch_n, mem_n;
        int         n_ir, n_imem, n_dmem, n_dwe, n_rf, n_alu, n_bad_we;
        logic       done, got_src;
        logic [3:0] op;
        logic [2:0] st;
        for (int i = 0; i <= imw; i++) q.push_back(0);
        q.push_back(1);
        q.push_back(2);
        if (t == 2'b10) begin
            for (int i = 0; i <= dmw; i++) q.push_back(3);
            if (m2r) q.push_back(4);
        end else if (t != 2'b11) begin
            q.push_back(4);
        end
        op = 4'($urandom_range(0, 14));
        {cyc, fetch_n, mem_n, n_ir, n_imem, n_dmem, n_dwe, n_rf, n_alu, n_bad_we} = '0;
        done    = 1'b0;
        got_src = 1'b0;
        while (!done && cyc < 64) begin
            st = bus.state;
            if (st == 3'd0 || st == 3'd1) drive_dec(op, t, rw, m2r, mw, br);
            else                          scramble_dec();
            bus.zero       = z;
            bus.imem_ready = (st == 3'd0) ? (fetch_n >= imw) : 1'($urandom);
            bus.dmem_ready = (st == 3'd3) ? (mem_n >= dmw)   : 1'($urandom);
            @(negedge clk);
            if (cyc < q.size()) check_eq("state_seq", 32'(bus.state), 32'(q[cyc]));
            n_ir     += int'(bus.ir_we);
            n_imem   += int'(bus.imem_req);
            n_dmem   += int'(bus.dmem_req);
            n_dwe    += int'(bus.dmem_we);
            n_rf     += int'(bus.rf_we);
            n_alu    += int'(bus.alu_en);
            n_bad_we += int'(bus.dmem_we & ~bus.dmem_req);
            if (st == 3'd0) fetch_n++;
            if (st == 3'd3) mem_n++;
            if (bus.pc_we) begin
                done    = 1'b1;
                got_src = bus.pc_src;
            end
            cyc++;
            @(posedge clk);
            #1;
        end
        check_eq("retired", 32'(done), 32'd1);
        check_eq("latency", 32'(cyc), 32'(q.size()));
        check_eq("ir_we_cnt", 32'(n_ir), 32'd1);
        check_eq("imem_req_cnt", 32'(n_imem), 32'(imw + 1));
        check_eq("alu_en_cnt", 32'(n_alu), 32'd1);
        check_eq("dmem_req_cnt", 32'(n_dmem), (t == 2'b10) ? 32'(dmw + 1) : 32'd0);
        check_eq("dmem_we_cnt", 32'(n_dwe), (t == 2'b10 && mw) ? 32'(dmw + 1) : 32'd0);
        check_eq("dmem_we_no_req", 32'(n_bad_we), 32'd0);
        check_eq("rf_we_cnt", 32'(n_rf),
                 (t == 2'b11) ? 32'd0 : (t == 2'b10) ? 32'(m2r & rw) : 32'(rw));
        check_eq("pc_src", 32'(got_src), (t == 2'b11) ? 32'(br & z) : 32'd0);
        exp_cnt++;
        check_eq("instr_count", 32'(bus.instr_count), exp_count());
    endtask

    function automatic int rand_wait();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 6) return 0;
        if (r == 9) return MEM_TIMEOUT;
        return int'($urandom_range(1, MEM_TIMEOUT));
    endfunction

    task automatic run_random(input int n);
        for (int i = 0; i < n; i++) begin
            run_instr(2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      1'($urandom), rand_wait(), rand_wait());
        end
    endtask

    task automatic wait_state(input logic [2:0] target, output int n);
        n = 0;
        while (bus.state != target && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        int n;
        do_reset(2);

        run_instr(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        run_instr(2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 3);
        run_instr(2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        run_instr(2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
        run_instr(2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        run_instr(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0);
        run_random(150);

        // Ready arriving on the very cycle the watchdog limit is reached.
        run_instr(2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, MEM_TIMEOUT, MEM_TIMEOUT);

        // Instruction fetch never answers.
        bus.imem_ready = 1'b0;
        for (int i = 0; i <= MEM_TIMEOUT; i++) begin
            @(negedge clk);
            check_eq("fetch_wait_state", 32'(bus.state), 32'd0);
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 5; i++) begin
            bus.imem_ready = 1'($urandom);
            bus.dmem_ready = 1'($urandom);
            @(negedge clk);
            check_eq("ifault_state", 32'(bus.state), 32'd6);
            check_eq("ifault_strobes", 32'(strobes), 32'd1);
            @(posedge clk);
            #1;
        end
        do_reset(1);

        // Load whose data access never completes.
        run_random(3);
        drive_dec(4'h3, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
        bus.imem_ready = 1'b1;
        bus.dmem_ready = 1'b0;
        wait_state(3'd3, n);
        check_eq("reach_mem", 32'(bus.state), 32'd3);
        n = 0;
        while (bus.state == 3'd3 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("mem_wait_cycles", 32'(n), 32'(MEM_TIMEOUT + 1));
        @(negedge clk);
        check_eq("dfault_state", 32'(bus.state), 32'd6);
        check_eq("dfault_strobes", 32'(strobes), 32'd1);
        check_eq("dfault_count", 32'(bus.instr_count), exp_count());
        @(posedge clk);
        #1;
        do_reset(1);

        // Halt opcode parks the sequencer.
        run_random(4);
        drive_dec(4'hF, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        bus.imem_ready = 1'b1;
        wait_state(3'd5, n);
        check_eq("halt_entry_cycles", 32'(n), 32'd2);
        for (int i = 0; i < 20; i++) begin
            scramble_dec();
            bus.imem_ready = 1'($urandom);
            bus.dmem_ready = 1'($urandom);
            bus.zero       = 1'($urandom);
            @(negedge clk);
            check_eq("halt_state", 32'(bus.state), 32'd5);
            check_eq("halt_strobes", 32'(strobes), 32'd2);
            @(posedge clk);
            #1;
        end
        check_eq("halt_count", 32'(bus.instr_count), exp_count());
        do_reset(1);

        // Reset in the middle of a data-memory wait.
        run_random(5);
        drive_dec(4'h2, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
        bus.imem_ready = 1'b1;
        bus.dmem_ready = 1'b0;
        wait_state(3'd3, n);
        check_eq("reach_mem2", 32'(bus.state), 32'd3);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        do_reset(1);
        run_random(5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control sequencer for the 32-bit RISC core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives the fetch and data-memory handshakes, the IR/PC/register-file write strobes and the ALU enable. It consumes the instruction decoder's outputs (tipo, reg_write, mem_to_reg, mem_write, branch) and the ALU zero flag. It adds a halt opcode, a memory-wait watchdog and a retired-instruction counter.

Parameters:
MEM_TIMEOUT, 15, max cycles a FETCH/MEM state waits for ready before FAULT (>=1)
HALT_OP, 4'b1111, opcode that stops the sequencer
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  core clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
opcode  in  4  IR opcode field (valid from DECODE onward)
tipo  in  2  decoder class: 00 R-type, 01 ALU-immediate, 10 load/store, 11 branch
reg_write  in  1  decoder RegWrite
mem_to_reg  in  1  decoder MemtoReg (1 = load)
mem_write  in  1  decoder MemWrite (1 = store)
branch  in  1  decoder Branch
zero  in  1  ALU zero flag, valid in EXEC
imem_ready  in  1  instruction memory data valid
dmem_ready  in  1  data memory access complete
imem_req  out  1  instruction fetch request
ir_we  out  1  instruction register load strobe
alu_en  out  1  ALU operand/result register enable
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write qualifier (valid only with dmem_req)
rf_we  out  1  register-file write strobe
pc_we  out  1  PC update strobe
pc_src  out  1  PC mux select: 0 = PC+4, 1 = branch target
state  out  3  current state encoding
instr_count  out  CNT_W  retired-instruction count
halted  out  1  HALT state flag
fault  out  1  FAULT state flag

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, FAULT=6. Codes 7 and any undefined value go to FAULT.
- Reset: clk rising edge with rst=1 sets state=FETCH, instr_count=0, wait timer=0 and latched decoder fields=0.
  - While rst=1, every strobe output is forced to 0, including imem_req, ir_we, alu_en, dmem_req, dmem_we, rf_we, pc_we, pc_src, halted and fault.
  - Reset in any state, including HALT/FAULT or mid-handshake, aborts the current operation with no retirement.
- FETCH: imem_req=1. ir_we = imem_ready (Mealy, same cycle). On imem_ready go to DECODE.
- DECODE: register tipo, reg_write, mem_to_reg, mem_write and branch. If opcode==HALT_OP go to HALT, otherwise go to EXEC. No strobes.
- EXEC: alu_en=1.
  - tipo 00/01: go to WB.
  - tipo 10: go to MEM.
  - tipo 11: pc_we=1, pc_src = branch_l & zero, retire, go to FETCH.
- MEM: dmem_req=1, dmem_we=mem_write_l. On dmem_ready:
  - If mem_to_reg_l: go to WB.
  - Otherwise (store): pc_we=1, pc_src=0, retire, go to FETCH.
- WB: rf_we=reg_write_l, pc_we=1, pc_src=0, retire, go to FETCH.
- HALT: halted=1, all strobes 0. Only rst exits HALT.
- FAULT: fault=1, all strobes 0. Only rst exits FAULT.
- Watchdog:
  - The timer clears on entry to FETCH or MEM and increments each cycle that state waits without ready.
  - When timer==MEM_TIMEOUT and ready is still low, go to FAULT.
  - If ready arrives in the same cycle the limit is reached, ready wins.
- Retire: instr_count increments by 1 in every cycle that pc_we=1. It wraps from all-ones to 0 silently.
- Latency with zero memory wait:
  - R/I-type: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch: 3 cycles
  - Each memory wait cycle adds 1.
- Decoder inputs are sampled only in DECODE. Changes in later states have no effect.

Test Plan:
- rst then R-type (tipo=00, reg_write=1), imem_ready tied 1 -> state 0,1,2,4,0. ir_we pulses in cycle 1 after rst; rf_we and pc_we both 1 in WB; instr_count=1.
- Load (tipo=10, mem_to_reg=1), dmem_ready delayed 3 cycles -> dmem_req high 4 cycles with dmem_we=0, then WB with rf_we=1; total 8 cycles.
- Store (tipo=10, mem_write=1), dmem_ready immediate -> dmem_we=1 for 1 cycle, pc_we=1 in the same cycle, rf_we never asserts.
- Branch (tipo=11, branch=1): zero=1 -> pc_src=1 in EXEC; repeat with zero=0 -> pc_src=0; both take 3 cycles and instr_count increments.
- imem_ready held 0 for MEM_TIMEOUT+1 cycles -> state=6 and fault=1 until rst. A second run with ready arriving exactly at the limit must reach DECODE, not FAULT.
- opcode=4'b1111 -> HALT, halted=1, no strobes for 20 cycles. Next, assert rst in the MEM state mid-wait: state=0, instr_count=0, dmem_req=0 during the rst cycle.
